seq_chunk_subtractor: RTL
=========================

// Module: seq_chunk_subtractor
// PURPOSE
//  Multi-cycle wide subtractor for the Balotelli ALU. It is the inverse-direction companion to the CLA adder path.
//  It computes D = A - B - BorrowIn over WIDTH bits, one CHUNK-bit slice per cycle, LSB slice first.
//  The borrow is registered between slices, so only a CHUNK-bit subtractor sits in the critical path.
//  Operands arrive on a valid/ready input channel. Results leave on a valid/ready output channel with flags.
// PARAMETERS
//  WIDTH   128  operand/result width; must be a multiple of CHUNK
//  CHUNK   32   slice width processed per cycle
//  NCHUNK  WIDTH/CHUNK (localparam)  slice count, >=1; counter width clog2(NCHUNK), min 1
// PORTS
//  Clk        in   1      clock; all state updates on posedge
//  Rst        in   1      reset, synchronous, active-low
//  InValid    in   1      operand request valid
//  InReady    out  1      block can accept operands
//  A          in   WIDTH  minuend
//  B          in   WIDTH  subtrahend
//  BorrowIn   in   1      borrow into slice 0
//  OutValid   out  1      result valid
//  OutReady   in   1      downstream accepts result
//  D          out  WIDTH  difference, modulo 2^WIDTH
//  BorrowOut  out  1      1 iff unsigned A < B + BorrowIn
//  Zero       out  1      D == 0
//  Ovf        out  1      signed overflow: A[W-1]!=B[W-1] && D[W-1]!=A[W-1]
// BEHAVIOUR
//  - Reset (Rst==0 at posedge): state=IDLE, slice counter=0, borrow reg=0, D=0, BorrowOut/Zero/Ovf=0, OutValid=0.
//    While Rst==0, InReady is forced to 0. Reset has priority over every other event.
//  - FSM has three states:
//    IDLE : InReady=1, OutValid=0. On InValid&&InReady, capture A, B and BorrowIn (borrow reg<=BorrowIn), set cnt=0, go to RUN.
//    RUN  : InReady=0. Each cycle:
//           {br,dk} = {1'b0,A[k]} - {1'b0,B[k]} - borrow, with k=cnt and slice k = bits [k*CHUNK +: CHUNK].
//           Write D[k]=dk and borrow<=br. If cnt==NCHUNK-1 go to DONE, else cnt++.
//    DONE : OutValid=1, InReady=0. D, BorrowOut, Zero and Ovf are held stable.
//           On OutReady go to IDLE; OutValid is 0 in the next cycle.
//  - Flags are registered when the last slice completes, so they are valid in the first DONE cycle:
//    BorrowOut=final borrow; Zero=(D==0); Ovf per the formula above, using the captured A and B.
//  - Latency: handshake at edge E0 -> OutValid=1 after edge E0+NCHUNK (4 cycles at the defaults).
//  - Throughput: one operation per NCHUNK+2 cycles at best. There is no overlap; InReady rises the cycle after the output handshake.
//  - Captured A and B are held internally, so input changes after acceptance have no effect.
//  - OutValid, once high, stays high with stable data until OutReady. OutReady is ignored outside DONE.
//  - InValid outside IDLE is ignored and never queued. The producer holds the request until InReady.
//  - Rst low mid-RUN or in DONE aborts the operation. No OutValid pulse is produced; the next operation is unaffected.
//  - NCHUNK==1: RUN lasts exactly one cycle, then DONE.
// TESTING
//  Defaults WIDTH=128, CHUNK=32. Check every result against an A-B-BorrowIn reference model.
//  1. A=5, B=3, BorrowIn=0 -> D=2, BorrowOut=0, Zero=0, Ovf=0. OutValid exactly 4 cycles after accept.
//  2. A=0, B=1, BorrowIn=0 -> D=2^128-1, BorrowOut=1, Ovf=0. Confirms the borrow ripples through all 4 slices.
//  3. A=2^127, B=1 -> D=2^127-1, Ovf=1, BorrowOut=0.
//     Then A=B=0x0123..CDEF, BorrowIn=0 -> Zero=1; same operands with BorrowIn=1 -> D=all ones, BorrowOut=1.
//  4. OutReady low for 10 cycles with InValid held high -> D and flags stable, InReady=0.
//     Second operand accepted 1 cycle after the OutReady handshake.
//  5. Rst=0 during the 2nd RUN cycle -> next cycle IDLE, D=0, OutValid never rises.
//     The following operation A=7, B=9 gives D=2^128-2, BorrowOut=1.
//  6. 10k random A/B/BorrowIn with random InValid/OutReady stalls -> all results match the model.
//     No lost or duplicated transactions; OutValid never drops without OutReady.

Source files
------------

// File: rtl/seq_chunk_subtractor_if.sv
// Operand/result channel bundle for the sliced subtractor.
// The master side is the producer of operands and the consumer of results.
interface seq_chunk_subtractor_if #(
    parameter int WIDTH = 128
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BorrowIn;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] D;
    logic             BorrowOut;
    logic             Zero;
    logic             Ovf;

    modport master (
        output InValid, A, B, BorrowIn, OutReady,
        input  InReady, OutValid, D, BorrowOut, Zero, Ovf
    );

    modport slave (
        input  InValid, A, B, BorrowIn, OutReady,
        output InReady, OutValid, D, BorrowOut, Zero, Ovf
    );
endinterface

// File: rtl/seq_chunk_subtractor.sv
// Multi-cycle D = A - B - BorrowIn, one CHUNK-bit slice per cycle, LSB slice first.
// The inter-slice borrow is registered so only a CHUNK-bit subtractor sits in the critical path.
module seq_chunk_subtractor #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    seq_chunk_subtractor_if.slave subIf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrowOut_q, borrowOut_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] aSlice, bSlice;
    logic [CHUNK:0]   diff;
    logic [WIDTH-1:0] dMerged;
    int               sliceBase;

    // Slice datapath: dMerged is the result word with the current slice already written in,
    // so the flags can be derived from it on the last slice.
    always_comb begin
        sliceBase = int'(cnt_q) * CHUNK;
        aSlice    = a_q[sliceBase +: CHUNK];
        bSlice    = b_q[sliceBase +: CHUNK];
        diff      = {1'b0, aSlice} - {1'b0, bSlice} - {{CHUNK{1'b0}}, borrow_q};
        dMerged   = d_q;
        dMerged[sliceBase +: CHUNK] = diff[CHUNK-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            borrowOut_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            borrowOut_q <= borrowOut_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        borrowOut_d = borrowOut_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (subIf.InValid) begin
                    a_d      = subIf.A;
                    b_d      = subIf.B;
                    borrow_d = subIf.BorrowIn;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                d_d      = dMerged;
                borrow_d = diff[CHUNK];
                if (cnt_q == LAST) begin
                    // Overflow compares the sign bits of the captured operands, not the live inputs.
                    borrowOut_d = diff[CHUNK];
                    zero_d      = (dMerged == '0);
                    ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dMerged[WIDTH-1] != a_q[WIDTH-1]);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (subIf.OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        subIf.InReady   = Rst && (state_q == IDLE);
        subIf.OutValid  = (state_q == DONE);
        subIf.D         = d_q;
        subIf.BorrowOut = borrowOut_q;
        subIf.Zero      = zero_q;
        subIf.Ovf       = ovf_q;
    end
endmodule
